// File: rtl/credit_sender.sv
// Credit-limited transmit stage: holds one producer word and issues it only while downstream credits remain.
// Optional direct issue from the producer when empty is enabled by defining CREDIT_SENDER_BYPASS_EN.
module credit_sender #(
    parameter int CREDITS = 3,
    parameter int DW      = 8,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          crd_ret,
    output logic [CW-1:0] crd_cnt,
    output logic          stall,
    output logic          crd_err
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HOLD  = 2'd1,
        S_STALL = 2'd2
    } state_t;

    localparam logic [CW-1:0] CREDITS_C = CW'(CREDITS);
    localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_r;
    logic [DW-1:0] hold_r;

    logic          send_s;
    logic          accept_s;
    logic          bypass_s;
    logic          issue_s;
    logic          load_s;
    logic          held_next_s;
    logic          over_ret_s;
    logic [CW-1:0] cnt_next_s;

    // Handshake, issue decision and next credit count.
    always_comb begin
        send_s   = (state_r != S_EMPTY) && (crd_cnt != ZERO_C);
        in_ready = (state_r == S_EMPTY) || send_s;
        accept_s = in_valid && in_ready;
        stall    = (state_r == S_STALL);
`ifdef CREDIT_SENDER_BYPASS_EN
        bypass_s = (state_r == S_EMPTY) && in_valid && (crd_cnt != ZERO_C);
`else
        bypass_s = 1'b0;
`endif
        issue_s     = send_s || bypass_s;
        // A bypassed word goes straight out and never occupies the hold register.
        load_s      = accept_s && !bypass_s;
        held_next_s = load_s || ((state_r != S_EMPTY) && !send_s);
        over_ret_s  = 1'b0;
        cnt_next_s  = crd_cnt;
        if (issue_s && !crd_ret) begin
            cnt_next_s = crd_cnt - ONE_C;
        end else if (!issue_s && crd_ret) begin
            if (crd_cnt == CREDITS_C) begin
                over_ret_s = 1'b1;
            end else begin
                cnt_next_s = crd_cnt + ONE_C;
            end
        end else begin
            cnt_next_s = crd_cnt;
        end
    end

    // State, hold register, issue outputs and credit bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_EMPTY;
            hold_r    <= {DW{1'b0}};
            out_valid <= 1'b0;
            out_data  <= {DW{1'b0}};
            crd_cnt   <= CREDITS_C;
            crd_err   <= 1'b0;
        end else begin
            if (held_next_s) begin
                state_r <= (cnt_next_s != ZERO_C) ? S_HOLD : S_STALL;
            end else begin
                state_r <= S_EMPTY;
            end
            if (load_s) begin
                hold_r <= in_data;
            end
            out_valid <= issue_s;
            if (issue_s) begin
                out_data <= bypass_s ? in_data : hold_r;
            end
            crd_cnt <= cnt_next_s;
            if (over_ret_s) begin
                crd_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/credit_sender.md
Name: credit_sender

Overview:
- Transmit end of the credit-limited transfer link.
- The receive end counts consumed slots and returns one credit pulse per freed slot. This block holds one outgoing word and issues it only while credits remain.
- Each issue consumes one credit; each crd_ret pulse restores one.
- Sits between a producer (valid/ready) and the downstream slot counter.

Parameters:
- CREDITS, 3, number of downstream slots; initial and maximum credit count (1..15).
- DW, 8, data word width.
- CW, 4, credit counter width; must satisfy 2^CW > CREDITS.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer offers in_data.
- in_data  in  DW  producer word.
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  1  one-cycle issue pulse to downstream (registered).
- out_data  out  DW  issued word (registered); valid only with out_valid.
- crd_ret  in  1  one-cycle credit-return pulse from the receive end.
- crd_cnt  out  CW  current credits available (registered).
- stall  out  1  word held but crd_cnt==0.
- crd_err  out  1  sticky: credit returned while already at CREDITS.

Behaviour:
- Reset (rst=1 at posedge), overriding all other inputs that cycle:
  - state=S_EMPTY, crd_cnt=CREDITS, out_valid=0, out_data=0, crd_err=0, hold register cleared.
  - A word held when reset hits is discarded.
  - Credits are restored to CREDITS and are not reconciled with in-flight words.
- States:
  - S_EMPTY: no word held.
  - S_HOLD: word held, crd_cnt>0.
  - S_STALL: word held, crd_cnt==0.
- Combinational terms:
  - send = (state!=S_EMPTY) && (crd_cnt!=0).
  - in_ready = (state==S_EMPTY) || send.
  - accept = in_valid && in_ready.
  - stall = (state==S_STALL).
- On send:
  - out_valid<=1 and out_data<=hold register on the next edge.
  - Otherwise out_valid<=0 and out_data keeps its value.
- Hold register loads in_data on accept.
  - Accept and send in the same cycle: the held word is issued and the new word replaces it (1 word/cycle sustained while credits last).
- State after each edge:
  - Held word present (accept, or held and not sent): S_HOLD if next crd_cnt>0, else S_STALL.
  - Otherwise: S_EMPTY.
- Credit arithmetic: crd_cnt_next = crd_cnt - send + crd_ret.
  - send and crd_ret in the same cycle: count unchanged.
  - crd_ret while crd_cnt==CREDITS and no send: count saturates at CREDITS; crd_err<=1 and remains 1 until reset.
  - crd_cnt never underflows, since send requires crd_cnt!=0.
- Latency (no bypass):
  - Accept at edge t.
  - Earliest send decision in the following cycle.
  - out_valid high in the cycle after edge t+1.
- Stall release: a crd_ret arriving in S_STALL sets crd_cnt=1 and state=S_HOLD at that edge; the send occurs the next cycle.
- in_valid with in_ready=0 has no effect.
- The producer must hold in_data stable until accepted.

Optional Feature:
- Macro: CREDIT_SENDER_BYPASS_EN.
- Defined:
  - When state==S_EMPTY && in_valid && crd_cnt!=0, the word is issued directly: out_valid<=1 and out_data<=in_data at the next edge, the credit is consumed, and the state stays S_EMPTY.
  - First-word latency drops by one cycle.
  - in_ready is unchanged.
- Undefined: every word passes through the hold register as specified above.

Test Plan (CREDITS=3, DW=8, bypass off unless stated):
- Reset: hold rst 2 cycles with in_valid=1 -> in_ready=1, crd_cnt=3, out_valid=0, crd_err=0, stall=0 throughout.
- Burst, no returns: in_valid=1 for 5 cycles, data 0x11..0x15 -> out_valid pulses carry 0x11,0x12,0x13 on consecutive cycles; crd_cnt 3->0; 0x14 held, stall=1, in_ready=0; 0x15 not accepted.
- Return releases stall: from that point, pulse crd_ret once -> next edge crd_cnt=1, stall=0; following cycle out_valid with 0x14 and crd_cnt=0; 0x15 accepted in the send cycle.
- Simultaneous send and return: crd_cnt=2, word held, crd_ret=1 -> out_valid next cycle, crd_cnt stays 2.
- Over-return and reset mid-stall: idle at crd_cnt=3, pulse crd_ret -> crd_cnt stays 3, crd_err=1 (sticky). Then rst during S_STALL -> held word never issued, crd_cnt=3, crd_err=0.
- Bypass (macro defined): empty, crd_cnt=3, in_valid with 0xA5 for one cycle -> out_valid with 0xA5 at the next edge (1 cycle vs 2 without the macro), crd_cnt=2, state stays S_EMPTY.
